reg_bank_arbiter: RTL

Round-robin arbiter and sequencer that shares a bank of NUM_REG 16-bit FunSel registers among NUM_REQ requesters. Each requester posts one register operation: target index, FunSel and load data. The arbiter grants one requester at a time and drives the selected register's E, the shared FunSel bus and the shared I bus for exactly one cycle. It then returns a one-cycle Done to that requester. The block sits between the control units and the register bank.

---
 rtl/reg_bank_arbiter_if.sv | 31 +++
 rtl/reg_bank_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter_if.sv
// Bus between the requesting control units, the arbiter and the register bank.
interface reg_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_REG = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_REG);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*SEL_W-1:0] req_sel;
  logic [NUM_REQ*2-1:0]     req_fun_sel;
  logic [NUM_REQ*16-1:0]    req_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REG-1:0]       reg_e;
  logic [1:0]               reg_fun_sel;
  logic [15:0]              reg_i;
  logic                     busy;

  // Requesters and bank observers
  modport master (
    output req, lock, req_sel, req_fun_sel, req_data,
    input  grant, done, reg_e, reg_fun_sel, reg_i, busy
  );

  // Arbiter side
  modport slave (
    input  req, lock, req_sel, req_fun_sel, req_data,
    output grant, done, reg_e, reg_fun_sel, reg_i, busy
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sequencing one register-bank operation at a time
// through IDLE -> ISSUE -> DONE, with optional lock for back-to-back ops.
module reg_bank_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_REG = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  reg_bank_arbiter_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(NUM_REG);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;       // last granted requester == current owner
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REG-1:0] rege_q, rege_d;
  logic [1:0]         fun_q, fun_d;
  logic [15:0]        data_q, data_d;

  logic [SEL_W-1:0]   sel_arr  [NUM_REQ];
  logic [1:0]         fun_arr  [NUM_REQ];
  logic [15:0]        data_arr [NUM_REQ];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               load;
  logic [IDX_W-1:0]   op_idx;

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.reg_e       = rege_q;
  assign bus.reg_fun_sel = fun_q;
  assign bus.reg_i       = data_q;
  assign bus.busy        = (state_q != IDLE);

  // Unpack the flat per-requester operand buses
  always_comb begin
    for (int unsigned c = 0; c < NUM_REQ; c++) begin
      sel_arr[c]  = bus.req_sel[c*SEL_W +: SEL_W];
      fun_arr[c]  = bus.req_fun_sel[c*2 +: 2];
      data_arr[c] = bus.req_data[c*16 +: 16];
    end
  end

  // Round-robin pick: first pass above the pointer, second pass wraps to it
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned c = 0; c < NUM_REQ; c++) begin
      if (!win_found && (c > 32'(ptr_q)) && bus.req[c]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
    for (int unsigned c = 0; c < NUM_REQ; c++) begin
      if (!win_found && (c <= 32'(ptr_q)) && bus.req[c]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
  end

  // Sequencer next state and operand capture
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    rege_d  = '0;
    fun_d   = fun_q;
    data_d  = data_q;
    load    = 1'b0;
    op_idx  = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ptr_d   = win_idx;
          op_idx  = win_idx;
          load    = 1'b1;
          state_d = ISSUE;
          for (int unsigned c = 0; c < NUM_REQ; c++) begin
            grant_d[c] = (win_idx == IDX_W'(c));
          end
        end
      end
      ISSUE: begin
        done_d  = grant_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.lock[ptr_q] && bus.req[ptr_q]) begin
          load    = 1'b1;
          state_d = ISSUE;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    if (load) begin
      fun_d  = fun_arr[op_idx];
      data_d = data_arr[op_idx];
      for (int unsigned r = 0; r < NUM_REG; r++) begin
        rege_d[r] = (sel_arr[op_idx] == SEL_W'(r));
      end
    end
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      rege_q  <= '0;
      fun_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rege_q  <= rege_d;
      fun_q   <= fun_d;
      data_q  <= data_d;
    end
  end
endmodule
